// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width for a run of n digits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: a + b + cin over WIDTH/DIGIT cycles with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b - cin when sub=1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, next_state;

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [DIGIT-1:0] digit_sum;
    logic             digit_co, digit_c_msb;
    logic             accept, last;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + ~cin == a - b - cin.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? ~cin : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt_q == LAST);

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (digit_sum),
        .co       (digit_co),
        .c_msb_in (digit_c_msb)
    );

    if (N == 1) begin : g_single
        assign acc_next = digit_sum;
    end else begin : g_shift
        assign acc_next = {digit_sum, acc_q[WIDTH-1:DIGIT]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = start ? RUN : IDLE;
            RUN:     next_state = (cnt_q == LAST) ? DONE : RUN;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            carry_q <= digit_co;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                sum  <= acc_next;
                cout <= digit_co;
                ovf  <= digit_c_msb ^ digit_co;
            end
        end
    end

    // NOTE: operand and partial-sum shift registers are fully loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b_in;
        end else if (state == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            acc_q <= acc_next;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances.
module tb_serial_adder;

    logic clk;
    logic rst;

    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8;
    logic       sub16;
`endif

    logic        start16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub16),
`endif
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One 8-bit operation starting at a negedge; scrambles inputs and pulses start while running.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec, input logic eo, input string tag);
        logic [7:0] prev;
        int         busy_n;
        prev   = sum8;
        a8     = va;
        b8     = vb;
        cin8   = vc;
        start8 = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom);
            end
            if (busy8 && !done8) busy_n++;
            if (i == 4) check({tag, " sum held"}, 32'(sum8), 32'(prev));
            start8 = (i % 2 == 1);
        end
        check({tag, " busy cycles"}, busy_n, 8);
        @(negedge clk);
        start8 = 1'b0;
        check({tag, " done"}, {busy8, done8}, 2'b01);
        check({tag, " sum"}, 32'(sum8), 32'(es));
        check({tag, " cout/ovf"}, {cout8, ovf8}, {ec, eo});
        @(negedge clk);
        check({tag, " done pulse"}, done8, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [7:0] prev;
        int         done_at [$];
        int         busy_n;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'hC0, 8'h80, 1'b0, 8'h40, 1'b1, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
        sub16 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset outputs8", {busy8, done8, sum8, cout8, ovf8}, 12'h000);
        check("reset outputs16", {busy16, done16, sum16, cout16, ovf16}, 20'h00000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                   $sformatf("vec%0d", i));

        // start held high: a result every 9 cycles, sum held mid-run
        prev = sum8;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            if (done8) begin
                done_at.push_back(c);
                check($sformatf("b2b sum at %0d", c), 32'(sum8), 32'h47);
            end
            if (c == 4) check("b2b held first run", 32'(sum8), 32'(prev));
            if (c == 13) check("b2b held second run", 32'(sum8), 32'h47);
            if (c == 26) start8 = 1'b0;
        end
        check("b2b pulse count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("b2b first done", done_at[0], 8);
            check("b2b period", done_at[1] - done_at[0], 9);
            check("b2b period2", done_at[2] - done_at[1], 9);
        end
        @(negedge clk);
        check("b2b idle", {busy8, done8}, 2'b00);

        // reset mid-run aborts and clears outputs
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort busy", busy8, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort outputs", {busy8, done8, sum8, cout8, ovf8}, 12'h000);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, "post-abort");

`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, "sub");
        sub8 = 1'b0;
`endif

        // 16-bit operands, 4-bit digits: four digit cycles
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (busy16 && !done16) busy_n++;
        end
        check("w16 busy cycles", busy_n, 4);
        @(negedge clk);
        check("w16 done", {busy16, done16}, 2'b01);
        check("w16 sum", 32'(sum16), 32'h0000);
        check("w16 cout/ovf", {cout16, ovf16}, 2'b10);
        @(negedge clk);
        check("w16 done pulse", done16, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit half adder cell.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, with a registered carry chain between digits.
- Start/busy/done handshake.
- Sits in the arithmetic datapath wherever area matters more than latency: counters, accumulators, checksum units.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 2.
- DIGIT, 1, bits added per clock; must divide WIDTH exactly. N = WIDTH/DIGIT is the run length in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new addition; sampled on the rising edge of clk
- a  in  WIDTH  operand A; sampled only when start is accepted
- b  in  WIDTH  operand B; sampled only when start is accepted
- cin  in  1  carry-in; sampled only when start is accepted
- busy  out  1  high while an addition is in progress
- done  out  1  one-cycle pulse when sum/cout become valid
- sum  out  WIDTH  result; held stable until the next accepted start
- cout  out  1  carry-out of the MSB
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state=IDLE; digit counter=0; carry register=0.
- FSM states:
  - IDLE: waiting for start.
  - RUN: adding digits.
  - DONE: one cycle, result valid.
- start is accepted when state is IDLE or DONE, so back-to-back operations are allowed.
- start is ignored in RUN; no queueing, no error flag.
- Accept at edge k:
  - latch a, b into shift registers; carry register = cin.
  - counter = 0; state = RUN; busy = 1.
  - sum, cout and ovf keep their previous values until completion.
- RUN, at each edge:
  - add the low DIGIT bits of A and B plus the carry register.
  - shift the DIGIT result bits into the top of the sum shift register.
  - carry register = digit carry-out.
  - counter increments.
- Completion at edge k+N (last digit):
  - sum and cout updated; ovf computed from this digit.
  - state = DONE; busy = 0; done = 1.
- Next edge after completion: done = 0; state = IDLE unless start is asserted, in which case a new accept occurs.
- Latency: done is high in the cycle beginning N edges after the accepting edge. Throughput is one result per N+1 cycles back-to-back.
- Arithmetic: unsigned modulo 2^WIDTH; the (WIDTH+1)-bit result is {cout, sum} = a + b + cin.
- Reset mid-operation: abort immediately; all outputs return to reset values; the partial result is discarded.
- Operand inputs may change freely while busy; only the values at acceptance matter.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), sampled with start.
  - when sub=1, B is latched inverted and the initial carry = ~cin, so the block computes a - b - cin.
  - cout = 1 means no borrow; ovf is signed overflow of the subtraction.
- Undefined: port sub is absent; addition only; behaviour exactly as above.

Decomposition:
- Shared package/include file holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and forces IDLE on the next edge.
  - the clog2-based counter-width constant.
- Natural sub-module: digit_adder. It is a combinational DIGIT-bit ripple adder built from full-adder cells, with ports x, y, ci, s, co and c_msb_in (carry into the top bit, used for ovf).

Test Plan (WIDTH=8, DIGIT=1 unless noted):
- a=8'hFF, b=8'h01, cin=0, start at edge 0 -> busy 1 for edges 0..7; done pulse after edge 8; sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- start held high continuously with a=8'h12, b=8'h34, cin=1 -> results 8'h47 repeat every 9 cycles; start pulses during RUN are ignored (sum unchanged mid-run).
- rst asserted at RUN cycle 4 of a=8'hAA, b=8'h55 -> next cycle busy=0, done=0, sum=0, cout=0; a fresh start then gives sum=8'hFF, cout=0.
- WIDTH=16, DIGIT=4, a=16'hFFFF, b=16'h0001 -> done 4 edges after accept; sum=16'h0000, cout=1.
- With SERIAL_ADDER_SUB_EN: sub=1, a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout=0 (borrow), ovf=0.
